// File: rtl/seg7_decode_if.sv
// rtl/seg7_decode_if.sv - decoded-value output handshake between seg7_decode and its consumer
//
// Signals:
//   out_valid  decoded event held in the producer's output register
//   out_ready  consumer accepts the held event this cycle
//   bcd        decoded value (0-7), meaningful when out_valid
//   err        with out_valid: the pattern was not a legal code
// Modports: master = producer (seg7_decode), slave = consumer.
interface seg7_decode_if;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] bcd;
  logic       err;

  modport master (
    output out_valid,
    output bcd,
    output err,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  bcd,
    input  err,
    output out_ready
  );
endinterface

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - recovers a 3-bit value from a debounced active-low 7-segment pattern
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-low reset
//   leds       incoming segment pattern, active-low, bit0=seg a ... bit6=seg g
//   dec        master side of seg7_decode_if (out_valid/out_ready/bcd/err)
//   overflow   sticky: an event was dropped because the output register was full
//   err_count  saturating count of illegal-pattern events, dropped ones included
module seg7_decode #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          leds,
  seg7_decode_if.master       dec,
  output logic                overflow,
  output logic [7:0]          err_count
);

  localparam logic [6:0] BLANK    = 7'b1111111;
  localparam logic [7:0] CNT_SAT  = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_QUAL = 8'(STABLE_CYCLES - 1);

  logic [6:0] cur;
  logic [7:0] cnt;
  logic [6:0] last;
  logic       last_valid;

  logic       legal;
  logic [2:0] value;
  logic       qualify;
  logic       event_gen;
  logic       load;

  always_comb begin
    legal = 1'b1;
    value = 3'd0;
    case (cur)
      7'b1000000: value = 3'd0;
      7'b1111001: value = 3'd1;
      7'b0100100: value = 3'd2;
      7'b0110000: value = 3'd3;
      7'b0011001: value = 3'd4;
      7'b0010010: value = 3'd5;
      7'b0000010: value = 3'd6;
      7'b1111000: value = 3'd7;
      default:    legal = 1'b0;
    endcase
  end

  // The counter saturates at STABLE_CYCLES, so the qualify cycle (one below
  // saturation) is hit exactly once per settled pattern.
  always_comb begin
    qualify   = (leds == cur) && (cnt == CNT_QUAL);
    event_gen = qualify && (cur != BLANK) && !(last_valid && (last == cur));
    load      = event_gen && (!dec.out_valid || dec.out_ready);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur           <= BLANK;
      cnt           <= 8'd0;
      last          <= BLANK;
      last_valid    <= 1'b0;
      dec.out_valid <= 1'b0;
      dec.bcd       <= 3'd0;
      dec.err       <= 1'b0;
      overflow      <= 1'b0;
      err_count     <= 8'd0;
    end else begin
      if (leds != cur) begin
        cur <= leds;
        cnt <= 8'd0;
      end else if (cnt < CNT_SAT) begin
        cnt <= cnt + 8'd1;
      end

      // A settled blank forgets the previous symbol so it can repeat.
      if (qualify) begin
        if (cur == BLANK) begin
          last_valid <= 1'b0;
        end else if (event_gen) begin
          last       <= cur;
          last_valid <= 1'b1;
        end
      end

      if (event_gen && !legal && (err_count != 8'hff)) begin
        err_count <= err_count + 8'd1;
      end

      if (event_gen) begin
        if (load) begin
          dec.out_valid <= 1'b1;
          dec.bcd       <= legal ? value : 3'd0;
          dec.err       <= !legal;
        end else begin
          overflow <= 1'b1;
        end
      end else if (dec.out_valid && dec.out_ready) begin
        dec.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_decode.sv
// tb/tb_seg7_decode.sv - directed self-checking bench for seg7_decode
module tb_seg7_decode;

  logic       clk;
  logic       reset;
  logic [6:0] leds;
  logic       overflow;
  logic [7:0] err_count;

  seg7_decode_if dec ();

  seg7_decode #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .leds      (leds),
    .dec       (dec),
    .overflow  (overflow),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] BLANK = 7'b1111111;
  logic [6:0] codes [8];
  initial begin
    codes[0] = 7'b1000000; codes[1] = 7'b1111001;
    codes[2] = 7'b0100100; codes[3] = 7'b0110000;
    codes[4] = 7'b0011001; codes[5] = 7'b0010010;
    codes[6] = 7'b0000010; codes[7] = 7'b1111000;
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Accepted events, captured mid-cycle: {err, bcd}
  logic [3:0] got_q [$];
  always @(negedge clk) begin
    if (reset && dec.out_valid && dec.out_ready) got_q.push_back({dec.err, dec.bcd});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b0;
    leds          = BLANK;
    dec.out_ready = 1'b1;

    // Reset state
    step(2);
    check("rst_valid", 32'(dec.out_valid), 0);
    check("rst_bcd", 32'(dec.bcd), 0);
    check("rst_err", 32'(dec.err), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_err_count", 32'(err_count), 0);

    // First pattern after release: valid after the 5th edge only
    got_q.delete();
    reset = 1'b1;
    leds  = codes[2];
    step(4);
    check("t1_not_yet", 32'(dec.out_valid), 0);
    step(1);
    check("t1_valid", 32'(dec.out_valid), 1);
    check("t1_bcd", 32'(dec.bcd), 2);
    check("t1_err", 32'(dec.err), 0);
    step(1);
    check("t1_drop", 32'(dec.out_valid), 0);
    step(10);
    check("t1_count", 32'(got_q.size()), 1);

    // Sweep of all legal codes separated by blanks
    got_q.delete();
    for (int i = 0; i < 8; i++) begin
      leds = BLANK;
      step(8);
      leds = codes[i];
      step(8);
    end
    leds = BLANK;
    step(8);
    check("sweep_count", 32'(got_q.size()), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      check($sformatf("sweep_ev%0d", i), 32'(got_q[i]), 32'(i));
    end
    check("sweep_overflow", 32'(overflow), 0);

    // Short glitch then return: single event only
    got_q.delete();
    leds = codes[1];
    step(8);
    leds = codes[6];
    step(2);
    leds = codes[1];
    step(8);
    check("glitch_count", 32'(got_q.size()), 1);
    if (got_q.size() > 0) check("glitch_ev", 32'(got_q[0]), 1);

    // Illegal pattern, then legal
    got_q.delete();
    leds = 7'b0000000;
    step(8);
    check("illegal_err_count", 32'(err_count), 1);
    leds = codes[7];
    step(8);
    check("legal_err_count", 32'(err_count), 1);
    check("illegal_count", 32'(got_q.size()), 2);
    if (got_q.size() > 1) begin
      check("illegal_ev", 32'(got_q[0]), 32'h8);
      check("legal_ev", 32'(got_q[1]), 7);
    end

    // Backpressure: second event dropped, overflow sticky
    got_q.delete();
    dec.out_ready = 1'b0;
    leds = BLANK;
    step(8);
    leds = codes[3];
    step(8);
    check("bp_valid", 32'(dec.out_valid), 1);
    check("bp_bcd3", 32'(dec.bcd), 3);
    check("bp_no_overflow", 32'(overflow), 0);
    leds = codes[5];
    step(8);
    check("bp_held_valid", 32'(dec.out_valid), 1);
    check("bp_held_bcd", 32'(dec.bcd), 3);
    check("bp_overflow", 32'(overflow), 1);
    dec.out_ready = 1'b1;
    step(1);
    check("bp_release", 32'(dec.out_valid), 0);
    step(10);
    check("bp_count", 32'(got_q.size()), 1);
    if (got_q.size() > 0) check("bp_ev", 32'(got_q[0]), 3);
    check("bp_overflow_sticky", 32'(overflow), 1);

    // Reset mid-settle with pattern held through release
    leds = BLANK;
    step(8);
    leds = codes[4];
    step(3);
    reset = 1'b0;
    step(1);
    check("mid_rst_valid", 32'(dec.out_valid), 0);
    check("mid_rst_overflow", 32'(overflow), 0);
    check("mid_rst_err_count", 32'(err_count), 0);
    got_q.delete();
    reset = 1'b1;
    step(4);
    check("mid_not_yet", 32'(dec.out_valid), 0);
    step(1);
    check("mid_valid", 32'(dec.out_valid), 1);
    check("mid_bcd", 32'(dec.bcd), 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_decode.md
Name: seg7_decode

Overview:
- Receive-side inverse of the team's 3-bit-to-7-segment encoder: samples an active-low 7-segment pattern bus and recovers the 3-bit value (0-7).
- Filters glitches with a stability counter, emits one decoded event per settled pattern change over a valid/ready handshake, and flags illegal patterns.
- Used wherever a board or FPGA region receives another unit's segment drive instead of a binary value (e.g. the peer-board link in the tug-of-war design).

Parameters:
- STABLE_CYCLES, 4, consecutive cycles leds must stay unchanged after capture before it qualifies; legal range 1..255.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset (reset==0 at a rising edge resets the block)
- leds  input  7  incoming segment pattern, active-low, bit0=seg a ... bit6=seg g
- out_ready  input  1  consumer accepts the output this cycle
- out_valid  output  1  decoded event held in output register
- bcd  output  3  decoded value; meaningful when out_valid
- err  output  1  with out_valid: pattern was not one of the 8 legal codes
- overflow  output  1  sticky; an event was dropped because the output register was full
- err_count  output  8  saturating count of illegal-pattern events generated, including dropped ones

Behaviour:
- Legal codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000. Blank=1111111.
- Reset state: out_valid=0, bcd=0, err=0, overflow=0, err_count=0. Internal capture register cur=1111111, stability counter cnt=0, last-emitted register empty.
- Filter, each edge:
  - If leds!=cur: cur<=leds, cnt<=0.
  - Else if cnt<STABLE_CYCLES: cnt<=cnt+1. cnt saturates at STABLE_CYCLES.
- Qualify: one cycle with leds==cur and cnt==STABLE_CYCLES-1. The qualify cycle occurs exactly once per settled pattern.
- Latency: leds changes to P before edge k and stays stable. out_valid rises after edge k+STABLE_CYCLES.
- On qualify:
  - cur==blank: no event; last-emitted becomes empty.
  - cur==last-emitted: no event.
  - Otherwise an event is generated and last-emitted<=cur.
    - Legal pattern: bcd=value, err=0.
    - Illegal pattern: bcd=0, err=1, err_count increments and saturates at 255.
- Output register:
  - Loads the event if out_valid==0, or if out_valid&&out_ready in the same cycle (back-to-back allowed).
  - Otherwise the event is dropped, overflow<=1 (sticky until reset), and last-emitted is still updated.
- out_valid&&out_ready with no new event: out_valid<=0 next edge. bcd and err keep their last values.
- out_valid, bcd and err are stable while out_valid&&!out_ready.
- A glitch shorter than STABLE_CYCLES+1 samples never produces an event, and returning to the previous pattern does not re-emit.
- Reset mid-operation: all state returns to reset values at that edge. A pattern already held through reset release is re-qualified as new: output after STABLE_CYCLES+1 edges, since cur restarts at blank.

Test Plan:
- Reset low 2 edges, then leds=0100100 held, out_ready=1 -> out_valid=1 for one cycle after 5th edge post-release, bcd=2, err=0; no further events while held.
- Sweep all 8 legal codes, each held 8 cycles, separated by blank 8 cycles -> exactly 8 events, bcd 0..7 in order, err=0, overflow=0.
- leds=1111001 settled, 2-cycle glitch to 0000010, back to 1111001 -> only one event (bcd=1); glitch ignored.
- leds=0000000 held 8 cycles -> event bcd=0, err=1, err_count=1; then 1111000 -> bcd=7, err=0, err_count stays 1.
- out_ready=0, present 3 then 5 (each held 8 cycles) -> bcd=3 held with out_valid=1, overflow=1 after 5 qualifies; raise out_ready -> out_valid drops, 5 never appears.
- Mid-settle (cnt=2) assert reset for one edge with leds=0011001 unchanged -> outputs zero; event bcd=4 appears 5 edges after release.
